mdio_mgmt_ctrl: RTL and testbench

//  MDIO (Clause 22) management master for the Ethernet PHY, shared between a host request port and an

---
 rtl/mdio_pkg.sv | 27 ++
 rtl/mdio_frame_engine.sv | 149 ++++++++++++++
 rtl/mdio_mgmt_ctrl.sv | 126 ++++++++++++
 tb/tb_mdio_mgmt_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// Shared MDIO Clause 22 constants, opcode and frame-engine state encodings.
package mdio_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b01,
        OP_READ  = 2'b10
    } mdio_op_e;

    localparam logic [1:0]  MDIO_ST          = 2'b01;
    localparam logic [4:0]  REG_BMCR         = 5'd0;
    localparam logic [4:0]  REG_BMSR         = 5'd1;
    localparam int unsigned BMSR_LINK_BIT    = 2;
    localparam int unsigned BMSR_AN_DONE_BIT = 5;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_START,
        ST_OP,
        ST_PHYAD,
        ST_REGAD,
        ST_TA,
        ST_DATA,
        ST_DONE
    } mdio_state_e;

endpackage

// File: rtl/mdio_frame_engine.sv
// MDC generator and bit-serial Clause 22 frame engine with start/done handshake.
module mdio_frame_engine
    import mdio_pkg::*;
#(
    parameter int unsigned CLK_DIV       = 20,
    parameter int unsigned PREAMBLE_BITS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mdio_i,
    input  logic        start,
    input  logic        start_write,
    input  logic [4:0]  start_phy,
    input  logic [4:0]  start_reg,
    input  logic [15:0] start_wdata,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    output logic        mdc_fall,
    output logic        idle,
    output logic        done,
    output logic [15:0] rdata
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV);

    mdio_state_e      state;
    logic [DIV_W-1:0] div_cnt;
    logic [5:0]       bit_cnt;
    logic [13:0]      hdr;
    logic [15:0]      shreg;
    logic             is_write;
    logic             div_end;
    logic             mdc_rise;

    // MDC edge strobes: true on the clk cycle whose edge toggles MDC
    always_comb begin
        div_end  = (div_cnt == DIV_W'(CLK_DIV - 1));
        mdc_fall = div_end && mdc;
        mdc_rise = div_end && !mdc;
        idle     = (state == ST_IDLE);
        done     = (state == ST_DONE);
        rdata    = shreg;
    end

    // Divider, frame FSM and data shift register; bus changes only on MDC falls
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt  <= '0;
            mdc      <= 1'b0;
            mdio_o   <= 1'b1;
            mdio_oe  <= 1'b0;
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            hdr      <= '0;
            shreg    <= '0;
            is_write <= 1'b0;
        end else begin
            if (div_end) begin
                div_cnt <= '0;
                mdc     <= ~mdc;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end

            if (mdc_rise && state == ST_DATA && !is_write)
                shreg <= {shreg[14:0], mdio_i};

            if (state == ST_DONE) begin
                state <= ST_IDLE;
            end else if (mdc_fall) begin
                // bit_cnt holds the bits still to go in the current field after the one now driven
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            state    <= ST_PREAMBLE;
                            bit_cnt  <= 6'(PREAMBLE_BITS - 1);
                            is_write <= start_write;
                            hdr      <= {MDIO_ST, start_write ? OP_WRITE : OP_READ, start_phy, start_reg};
                            shreg    <= start_wdata;
                            mdio_o   <= 1'b1;
                            mdio_oe  <= 1'b1;
                        end
                    end
                    ST_PREAMBLE: begin
                        if (bit_cnt == '0) begin
                            state   <= ST_START;
                            bit_cnt <= 6'd1;
                            mdio_o  <= hdr[13];
                            hdr     <= {hdr[12:0], 1'b0};
                        end else begin
                            bit_cnt <= bit_cnt - 6'd1;
                        end
                    end
                    ST_START, ST_OP, ST_PHYAD: begin
                        mdio_o <= hdr[13];
                        hdr    <= {hdr[12:0], 1'b0};
                        if (bit_cnt == '0) begin
                            state   <= (state == ST_START) ? ST_OP : (state == ST_OP) ? ST_PHYAD : ST_REGAD;
                            bit_cnt <= (state == ST_START) ? 6'd1 : 6'd4;
                        end else begin
                            bit_cnt <= bit_cnt - 6'd1;
                        end
                    end
                    ST_REGAD: begin
                        if (bit_cnt == '0) begin
                            state   <= ST_TA;
                            bit_cnt <= 6'd1;
                            mdio_o  <= 1'b1;
                            mdio_oe <= is_write;
                        end else begin
                            bit_cnt <= bit_cnt - 6'd1;
                            mdio_o  <= hdr[13];
                            hdr     <= {hdr[12:0], 1'b0};
                        end
                    end
                    ST_TA: begin
                        if (bit_cnt == '0) begin
                            state   <= ST_DATA;
                            bit_cnt <= 6'd15;
                            if (is_write) begin
                                mdio_o <= shreg[15];
                                shreg  <= {shreg[14:0], 1'b0};
                            end
                        end else begin
                            bit_cnt <= bit_cnt - 6'd1;
                            mdio_o  <= ~is_write;
                        end
                    end
                    ST_DATA: begin
                        if (bit_cnt == '0) begin
                            state   <= ST_DONE;
                            mdio_oe <= 1'b0;
                            mdio_o  <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt - 6'd1;
                            if (is_write) begin
                                mdio_o <= shreg[15];
                                shreg  <= {shreg[14:0], 1'b0};
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/mdio_mgmt_ctrl.sv
// MDIO management master: host port plus periodic BMSR poller sharing one frame engine.
module mdio_mgmt_ctrl
    import mdio_pkg::*;
#(
    parameter int unsigned CLK_DIV       = 20,
    parameter int unsigned POLL_INTERVAL = 1_000_000,
    parameter logic [4:0]  POLL_PHY_ADDR = 5'd1,
    parameter int unsigned PREAMBLE_BITS = 32
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i,
    input  logic        poll_en,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [4:0]  req_phy,
    input  logic [4:0]  req_reg,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        busy,
    output logic        link_up,
    output logic        an_done
);

    localparam int unsigned PW = $clog2(POLL_INTERVAL);

    logic [PW-1:0] poll_cnt;
    logic          poll_pending;
    logic          cur_host;
    logic          cur_write;
    logic          mdc_fall;
    logic          eng_idle;
    logic          eng_done;
    logic [15:0]   eng_rdata;
    logic          start_host;
    logic          start_poll;
    logic          eng_start;
    logic          eng_write;
    logic [4:0]    eng_phy;
    logic [4:0]    eng_reg;

    // Arbitration at an idle MDC fall: host wins, a pending poll waits for the next free fall
    always_comb begin
        start_host = eng_idle && mdc_fall && req_valid;
        start_poll = eng_idle && mdc_fall && !req_valid && poll_pending;
        eng_start  = start_host || start_poll;
        eng_write  = start_host && req_write;
        eng_phy    = start_host ? req_phy : POLL_PHY_ADDR;
        eng_reg    = start_host ? req_reg : REG_BMSR;
    end

    // Poll interval timer; expiry is latched until a poll frame actually starts
    always_ff @(posedge clk) begin
        if (!rst || !poll_en) begin
            poll_cnt     <= '0;
            poll_pending <= 1'b0;
        end else if (poll_cnt == PW'(POLL_INTERVAL - 1)) begin
            poll_cnt     <= '0;
            poll_pending <= 1'b1;
        end else begin
            poll_cnt <= poll_cnt + PW'(1);
            if (start_poll)
                poll_pending <= 1'b0;
        end
    end

    // Handshake, busy flag, host response and polled link status registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            busy      <= 1'b0;
            link_up   <= 1'b0;
            an_done   <= 1'b0;
            cur_host  <= 1'b0;
            cur_write <= 1'b0;
        end else begin
            req_ready <= start_host;
            rsp_valid <= 1'b0;
            if (eng_start) begin
                busy      <= 1'b1;
                cur_host  <= start_host;
                cur_write <= eng_write;
            end
            if (eng_done) begin
                busy <= 1'b0;
                if (cur_host) begin
                    rsp_valid <= 1'b1;
                    if (!cur_write)
                        rsp_rdata <= eng_rdata;
                end else begin
                    link_up <= eng_rdata[BMSR_LINK_BIT];
                    an_done <= eng_rdata[BMSR_AN_DONE_BIT];
                end
            end
        end
    end

    mdio_frame_engine #(
        .CLK_DIV       (CLK_DIV),
        .PREAMBLE_BITS (PREAMBLE_BITS)
    ) u_engine (
        .clk         (clk),
        .rst         (rst),
        .mdio_i      (mdio_i),
        .start       (eng_start),
        .start_write (eng_write),
        .start_phy   (eng_phy),
        .start_reg   (eng_reg),
        .start_wdata (req_wdata),
        .mdc         (mdc),
        .mdio_o      (mdio_o),
        .mdio_oe     (mdio_oe),
        .mdc_fall    (mdc_fall),
        .idle        (eng_idle),
        .done        (eng_done),
        .rdata       (eng_rdata)
    );

endmodule

// File: tb/tb_mdio_mgmt_ctrl.sv
// Bench for mdio_mgmt_ctrl: bus monitor + PHY register model, randomized host traffic, polls.
module tb_mdio_mgmt_ctrl;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned POLL_INTERVAL = 2000;
    localparam int unsigned PREAMBLE_BITS = 32;

    typedef struct packed {
        logic [1:0]  st;
        logic [1:0]  op;
        logic [4:0]  phy;
        logic [4:0]  rg;
        logic [1:0]  ta;
        logic [1:0]  ta_oe;
        logic        data_oe_any;
        logic [15:0] data;
        logic [7:0]  pre;
        logic [31:0] rise_at;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mdc, mdio_o, mdio_oe;
    logic        mdio_i = 1'b1;
    logic        poll_en, req_valid, req_ready, req_write;
    logic [4:0]  req_phy, req_reg;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        busy, link_up, an_done;

    int total = 0;
    int bad = 0;

    logic [15:0] phy_regs [32][32];
    logic [15:0] exp_mem  [32][32];
    logic [15:0] exp_rdata = '0;
    frame_t      frame_q [$];
    int          rst_epoch = 0;
    int          seen_epoch = 0;
    int          rsp_cnt = 0;
    int          rsp_long = 0;
    logic        rsp_prev = 1'b0;
    logic [15:0] rsp_last = '0;
    logic        in_frame = 1'b0;
    int          pos = 0;
    int          ones = 0;
    int unsigned rise_cnt = 0;
    frame_t      cur;
    logic [31:0] last_host_rise = '0;

    always #5 clk = ~clk;

    mdio_mgmt_ctrl #(
        .CLK_DIV       (CLK_DIV),
        .POLL_INTERVAL (POLL_INTERVAL),
        .POLL_PHY_ADDR (5'd1),
        .PREAMBLE_BITS (PREAMBLE_BITS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mdc       (mdc),
        .mdio_o    (mdio_o),
        .mdio_oe   (mdio_oe),
        .mdio_i    (mdio_i),
        .poll_en   (poll_en),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_phy   (req_phy),
        .req_reg   (req_reg),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .link_up   (link_up),
        .an_done   (an_done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Bus monitor and PHY: samples each MDC rise, decodes frames, serves read data MSB first
    always @(posedge mdc) begin
        logic [15:0] word;
        #1;
        rise_cnt++;
        if (seen_epoch != rst_epoch) begin
            seen_epoch = rst_epoch;
            in_frame = 1'b0;
            ones = 0;
            mdio_i = 1'b1;
        end
        if (!in_frame) begin
            if (mdio_oe && mdio_o) ones++;
            else if (mdio_oe && !mdio_o && ones > 0) begin
                in_frame = 1'b1;
                pos = 32;
                cur = '0;
                cur.pre = 8'(ones);
                cur.rise_at = rise_cnt;
            end else ones = 0;
        end else begin
            pos++;
            if (pos == 33) cur.st[0] = mdio_o;
            else if (pos <= 35) cur.op[35-pos] = mdio_o;
            else if (pos <= 40) cur.phy[40-pos] = mdio_o;
            else if (pos <= 45) cur.rg[45-pos] = mdio_o;
            else if (pos <= 47) begin
                cur.ta[47-pos] = mdio_o;
                cur.ta_oe[47-pos] = mdio_oe;
            end else begin
                cur.data[63-pos] = mdio_o;
                if (mdio_oe) cur.data_oe_any = 1'b1;
            end
            if (cur.op == 2'b10) begin
                if (pos == 46) mdio_i = 1'b0;
                else if (pos >= 47 && pos <= 62) begin
                    word = phy_regs[cur.phy][cur.rg];
                    mdio_i = word[62-pos];
                end
            end
            if (pos == 63) begin
                mdio_i = 1'b1;
                if (cur.op == 2'b01) phy_regs[cur.phy][cur.rg] = cur.data;
                frame_q.push_back(cur);
                in_frame = 1'b0;
                ones = 0;
            end
        end
    end

    // Host response tracker
    always @(negedge clk) begin
        if (rsp_valid) begin
            rsp_cnt++;
            rsp_last = rsp_rdata;
            if (rsp_prev) rsp_long++;
        end
        rsp_prev = rsp_valid;
    end

    task automatic check_frame(input frame_t f, input logic w, input logic [4:0] p, input logic [4:0] r);
        check_eq("preamble_len", 32'(f.pre), PREAMBLE_BITS);
        check_eq("st", 32'(f.st), 32'h1);
        check_eq("op", 32'(f.op), w ? 32'h1 : 32'h2);
        check_eq("phyad", 32'(f.phy), 32'(p));
        check_eq("regad", 32'(f.rg), 32'(r));
        if (w) begin
            check_eq("ta_write", 32'(f.ta), 32'h2);
            check_eq("ta_oe_write", 32'(f.ta_oe), 32'h3);
        end else begin
            check_eq("ta_oe_read", 32'(f.ta_oe), 32'h0);
            check_eq("data_oe_read", 32'(f.data_oe_any), 32'h0);
        end
    endtask

    task automatic wait_frame(output int ok);
        ok = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (frame_q.size() > 0) begin ok = 1; break; end
        end
    endtask

    task automatic wait_idle(output int ok);
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
        end
    endtask

    task automatic host_xfer(input logic w, input logic [4:0] p, input logic [4:0] r,
                             input logic [15:0] d, input logic expect_idle);
        int n0;
        int ok;
        frame_t f;
        n0 = rsp_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_phy = p; req_reg = r; req_wdata = d;
        ok = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1; break; end
        end
        check_eq("req_accept", ok, 1);
        check_eq("busy_on_accept", 32'(busy), 1);
        req_valid = 1'b0;
        req_write = 1'($urandom); req_phy = 5'($urandom); req_reg = 5'($urandom);
        req_wdata = 16'($urandom);
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (rsp_cnt != n0) begin ok = 1; break; end
        end
        check_eq("rsp_seen", ok, 1);
        repeat (3) @(negedge clk);
        check_eq("rsp_pulses", rsp_cnt, n0 + 1);
        if (expect_idle) begin
            check_eq("busy_after", 32'(busy), 0);
            check_eq("oe_after", 32'(mdio_oe), 0);
            check_eq("mdio_o_after", 32'(mdio_o), 1);
        end
        if (frame_q.size() == 0) check_eq("frame_seen", 0, 1);
        else begin
            f = frame_q.pop_front();
            last_host_rise = f.rise_at;
            check_frame(f, w, p, r);
            if (w) check_eq("wdata_on_wire", 32'(f.data), 32'(d));
        end
        if (w) exp_mem[p][r] = d;
        else exp_rdata = exp_mem[p][r];
        check_eq("rsp_rdata_at_pulse", 32'(rsp_last), 32'(exp_rdata));
        check_eq("rsp_rdata_held", 32'(rsp_rdata), 32'(exp_rdata));
    endtask

    task automatic poll_check(input logic exp_link, input logic exp_an, input int n0);
        int ok;
        frame_t f;
        wait_frame(ok);
        check_eq("poll_frame_seen", ok, 1);
        if (ok == 1) begin
            f = frame_q.pop_front();
            check_frame(f, 1'b0, 5'd1, 5'd1);
        end
        wait_idle(ok);
        check_eq("poll_idle", ok, 1);
        repeat (2) @(negedge clk);
        check_eq("link_up", 32'(link_up), 32'(exp_link));
        check_eq("an_done", 32'(an_done), 32'(exp_an));
        check_eq("poll_no_rsp", rsp_cnt, n0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int ok;
        int cyc;
        int n0;
        logic prev;
        frame_t f;
        logic w;
        logic [4:0] p, r;
        logic [15:0] d;

        for (int i = 0; i < 32; i++)
            for (int j = 0; j < 32; j++) begin
                d = 16'($urandom);
                phy_regs[i][j] = d;
                exp_mem[i][j] = d;
            end

        rst = 1'b0; poll_en = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_phy = '0; req_reg = '0; req_wdata = '0;
        repeat (5) @(negedge clk);
        check_eq("rst_mdc", 32'(mdc), 0);
        check_eq("rst_mdio_o", 32'(mdio_o), 1);
        check_eq("rst_mdio_oe", 32'(mdio_oe), 0);
        check_eq("rst_req_ready", 32'(req_ready), 0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 0);
        check_eq("rst_rsp_rdata", 32'(rsp_rdata), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_link_up", 32'(link_up), 0);
        check_eq("rst_an_done", 32'(an_done), 0);
        rst = 1'b1;

        // MDC period, measured between rises in clk cycles
        for (int k = 0; k < 3; k++) begin
            prev = mdc; cyc = 0; ok = 0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                cyc++;
                if (mdc && !prev) begin ok = 1; break; end
                prev = mdc;
            end
            check_eq("mdc_rise_seen", ok, 1);
            if (k > 0) check_eq("mdc_period", cyc, 2 * CLK_DIV);
        end

        // Directed write then read
        host_xfer(1'b1, 5'd1, 5'd0, 16'h1200, 1'b1);
        phy_regs[1][2] = 16'h0022; exp_mem[1][2] = 16'h0022;
        host_xfer(1'b0, 5'd1, 5'd2, 16'hA5A5, 1'b1);

        // Randomized host traffic against the PHY model
        for (int k = 0; k < 12; k++) begin
            repeat ($urandom_range(0, 40)) @(negedge clk);
            w = 1'($urandom); p = 5'($urandom); r = 5'($urandom); d = 16'($urandom);
            host_xfer(w, p, r, d, 1'b1);
        end

        // Periodic BMSR polling
        phy_regs[1][1] = 16'h786D; exp_mem[1][1] = 16'h786D;
        n0 = rsp_cnt;
        @(negedge clk); poll_en = 1'b1;
        poll_check(1'b1, 1'b1, n0);
        phy_regs[1][1] = 16'h7849; exp_mem[1][1] = 16'h7849;
        poll_check(1'b0, 1'b0, n0);
        @(negedge clk); poll_en = 1'b0;
        repeat (10) @(negedge clk);

        // Host request lands on the cycle the poll timer expires
        phy_regs[1][1] = 16'h0004; exp_mem[1][1] = 16'h0004;
        @(negedge clk); poll_en = 1'b1;
        repeat (POLL_INTERVAL) @(posedge clk);
        host_xfer(1'b1, 5'd3, 5'd4, 16'($urandom), 1'b0);
        n0 = rsp_cnt;
        wait_frame(ok);
        check_eq("deferred_poll_seen", ok, 1);
        if (ok == 1) begin
            f = frame_q.pop_front();
            check_frame(f, 1'b0, 5'd1, 5'd1);
            check_eq("poll_follows_host", 32'((f.rise_at - last_host_rise >= PREAMBLE_BITS + 32) &&
                                               (f.rise_at - last_host_rise <= PREAMBLE_BITS + 33)), 1);
        end
        wait_idle(ok);
        @(negedge clk); poll_en = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("coll_link_up", 32'(link_up), 1);
        check_eq("coll_an_done", 32'(an_done), 0);
        check_eq("coll_no_rsp", rsp_cnt, n0);
        frame_q.delete();

        // Reset in the middle of read data
        n0 = rsp_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_phy = 5'd1; req_reg = 5'd2;
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1; break; end
        end
        check_eq("abort_accept", ok, 1);
        req_valid = 1'b0;
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (in_frame && pos >= 54) begin ok = 1; break; end
        end
        check_eq("abort_reached_data", ok, 1);
        check_eq("abort_busy_before", 32'(busy), 1);
        rst = 1'b0;
        @(negedge clk);
        check_eq("abort_oe", 32'(mdio_oe), 0);
        check_eq("abort_busy", 32'(busy), 0);
        check_eq("abort_rsp_valid", 32'(rsp_valid), 0);
        check_eq("abort_mdc", 32'(mdc), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1; rst_epoch++;
        exp_rdata = '0;
        repeat (600) @(negedge clk);
        check_eq("abort_no_rsp", rsp_cnt, n0);
        check_eq("abort_no_frame", frame_q.size(), 0);
        check_eq("abort_rdata_cleared", 32'(rsp_rdata), 0);
        host_xfer(1'b0, 5'd1, 5'd2, 16'h0, 1'b1);

        check_eq("rsp_one_cycle", rsp_long, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
